// File: rtl/entrada_handshake_pkg.sv
// Shared definitions for the processor input path.
//   estado_e : handshake FSM states (2-bit encoding)
//   PalavraW : width of the DE2 switch word SW[17:0]
package processador_defs;

  localparam int unsigned PalavraW = 18;

  typedef enum logic [1:0] {
    Ocioso = 2'd0,  // no request from the control unit
    Espera = 2'd1,  // request pending, waiting for a confirmed press
    Pronto = 2'd2,  // value captured, sinal held high
    Libera = 2'd3   // request withdrawn, waiting for the button to be released
  } estado_e;

endpackage

// File: rtl/entrada_handshake_debounce.sv
// Pushbutton conditioner: synchroniser, debouncer and press-edge detector.
// Ports:
//   clock    in   board clock
//   reset    in   synchronous, active-low reset
//   botao_in in   raw active-low pushbutton (asynchronous)
//   nivel    out  debounced button level (1 = released)
//   press    out  one-cycle pulse on a debounced 1->0 transition
module debounce_botao #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clock,
  input  logic reset,
  input  logic botao_in,
  output logic nivel,
  output logic press
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   nivel_q, nivel_d;
  logic                   press_q, press_d;

  assign synced = sync_q[SYNC_STAGES-1];

  // Counter tracks how many consecutive cycles the synced value has disagreed
  // with the debounced level; any agreement restarts the window.
  always_comb begin
    cnt_d   = '0;
    nivel_d = nivel_q;
    press_d = 1'b0;
    if (synced != nivel_q) begin
      if (cnt_q == CntMax) begin
        nivel_d = synced;
        press_d = ~synced;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      nivel_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], botao_in};
      cnt_q   <= cnt_d;
      nivel_q <= nivel_d;
      press_q <= press_d;
    end
  end

  assign nivel = nivel_q;
  assign press = press_q;

endmodule

// File: rtl/entrada_handshake.sv
// Processor input stage: conditions the ENTER key and captures the switch word
// on a confirmed press, answering a level request from the control unit.
// Ports:
//   clock      in   board clock (only clock)
//   reset      in   synchronous, active-low reset
//   enter      in   raw ENTER key, active-low, asynchronous
//   entrada    in   switch word SW[17:0]
//   in         in   control-unit request level
//   sinal      out  value ready; held until `in` falls
//   valor      out  captured switch word, stable while sinal=1
//   aguardando out  request pending and no press yet (LED)
module entrada_handshake
  import processador_defs::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enter,
  input  logic [PalavraW-1:0] entrada,
  input  logic                in,
  output logic                sinal,
  output logic [PalavraW-1:0] valor,
  output logic                aguardando
);

  logic nivel;
  logic press;

  debounce_botao #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clock   (clock),
    .reset   (reset),
    .botao_in(enter),
    .nivel   (nivel),
    .press   (press)
  );

  estado_e             estado_q, estado_d;
  logic [PalavraW-1:0] valor_q, valor_d;
  logic                sinal_q, sinal_d;
  logic                aguardando_q, aguardando_d;

  always_comb begin
    estado_d = estado_q;
    valor_d  = valor_q;
    unique case (estado_q)
      Ocioso: begin
        // Presses seen here are deliberately dropped, not buffered.
        if (in) estado_d = Espera;
      end
      Espera: begin
        // A withdrawn request beats a press arriving in the same cycle.
        if (!in) begin
          estado_d = Ocioso;
        end else if (press) begin
          valor_d  = entrada;
          estado_d = Pronto;
        end
      end
      Pronto: begin
        if (!in) estado_d = Libera;
      end
      Libera: begin
        // Holding the key must not satisfy a following request.
        if (nivel) estado_d = Ocioso;
      end
      default: estado_d = Ocioso;
    endcase
    // Outputs are decoded from the next state so they register with it.
    sinal_d      = (estado_d == Pronto);
    aguardando_d = (estado_d == Espera);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado_q     <= Ocioso;
      valor_q      <= '0;
      sinal_q      <= 1'b0;
      aguardando_q <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      valor_q      <= valor_d;
      sinal_q      <= sinal_d;
      aguardando_q <= aguardando_d;
    end
  end

  assign sinal      = sinal_q;
  assign valor      = valor_q;
  assign aguardando = aguardando_q;

endmodule

// File: tb/tb_entrada_handshake.sv
module tb_entrada_handshake;

  localparam int unsigned D = 4;
  localparam int unsigned S = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enter = 1'b1;
  logic        in_r  = 1'b0;
  logic [17:0] entrada = '0;
  logic        sinal;
  logic [17:0] valor;
  logic        aguardando;

  always #5 clock = ~clock;

  entrada_handshake #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3),
    .SYNC_STAGES    (S)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enter     (enter),
    .entrada   (entrada),
    .in        (in_r),
    .sinal     (sinal),
    .valor     (valor),
    .aguardando(aguardando)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  int rises = 0;
  logic sinal_prev = 1'b0;

  // Reference model: the key is debounced by looking at the raw history
  // (a level change needs D consecutive synced samples disagreeing with it);
  // the handshake is kept as a few meaning-level flags.
  logic        raw_h [S+D];
  logic        m_nivel = 1'b1;
  logic        m_press = 1'b0;
  logic        m_pend  = 1'b0;
  logic        m_ready = 1'b0;
  logic        m_rel   = 1'b0;
  logic [17:0] m_valor = '0;

  always @(posedge clock) begin
    logic press_now, nivel_now, flip;
    if (!reset) begin
      m_ready = 1'b0; m_pend = 1'b0; m_rel = 1'b0; m_valor = '0;
      m_nivel = 1'b1; m_press = 1'b0;
      for (int i = 0; i < S + D; i++) raw_h[i] = 1'b1;
    end else begin
      press_now = m_press;
      nivel_now = m_nivel;
      if (m_ready) begin
        if (!in_r) begin m_ready = 1'b0; m_rel = 1'b1; end
      end else if (m_pend) begin
        if (!in_r) m_pend = 1'b0;
        else if (press_now) begin m_valor = entrada; m_pend = 1'b0; m_ready = 1'b1; end
      end else if (m_rel) begin
        if (nivel_now) m_rel = 1'b0;
      end else if (in_r) begin
        m_pend = 1'b1;
      end
      for (int i = S + D - 1; i > 0; i--) raw_h[i] = raw_h[i-1];
      raw_h[0] = enter;
      // raw_h[S] is what leaves the synchroniser ahead of this edge.
      flip = 1'b1;
      for (int i = S; i < S + D; i++) if (raw_h[i] == m_nivel) flip = 1'b0;
      if (flip) begin
        m_nivel = ~m_nivel;
        m_press = ~m_nivel;
      end else begin
        m_press = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("model sinal", 32'(sinal), 32'(m_ready));
      chk("model aguardando", 32'(aguardando), 32'(m_pend));
      chk("model valor", 32'(valor), 32'(m_valor));
    end
    if (sinal === 1'b1 && sinal_prev === 1'b0) rises++;
    sinal_prev = sinal;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_sinal(input int budget, input string name);
    int k = 0;
    while (sinal !== 1'b1 && k < budget) begin
      cyc(1);
      k++;
    end
    chk(name, 32'(sinal), 32'd1);
  endtask

  int hold = 0;

  initial begin
    // 1. Reset
    cyc(1);
    chk_en = 1'b1;
    cyc(2);
    chk("reset sinal", 32'(sinal), 32'd0);
    chk("reset valor", 32'(valor), 32'd0);
    chk("reset aguardando", 32'(aguardando), 32'd0);
    reset = 1'b1;
    cyc(2);

    // 2. Normal handshake, exact latency
    entrada = 18'h2A5F3;
    in_r = 1'b1;
    cyc(2);
    chk("t2 aguardando", 32'(aguardando), 32'd1);
    enter = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      chk($sformatf("t2 sinal after %0d", i), 32'(sinal), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("t2 valor", 32'(valor), 32'h2A5F3);
    entrada = 18'h01234;
    cyc(3);
    chk("t2 valor frozen", 32'(valor), 32'h2A5F3);
    enter = 1'b1;
    in_r = 1'b0;
    cyc(1);
    chk("t2 sinal drop", 32'(sinal), 32'd0);
    cyc(10);

    // 3. Bouncing key
    rises = 0;
    entrada = 18'h15555;
    in_r = 1'b1;
    cyc(2);
    for (int k = 0; k < 6; k++) begin
      enter = ~enter;
      cyc(2);
      chk("t3 no sinal while bouncing", 32'(sinal), 32'd0);
    end
    enter = 1'b0;
    wait_sinal(20, "t3 sinal after settle");
    cyc(5);
    chk("t3 one capture", 32'(rises), 32'd1);
    chk("t3 valor", 32'(valor), 32'h15555);
    in_r = 1'b0;
    enter = 1'b1;
    cyc(12);

    // 4. Key held across in 1->0->1
    entrada = 18'h0BEEF;
    in_r = 1'b1;
    enter = 1'b0;
    wait_sinal(20, "t4 first sinal");
    chk("t4 first valor", 32'(valor), 32'h0BEEF);
    in_r = 1'b0;
    cyc(2);
    in_r = 1'b1;
    entrada = 18'h3C0DE;
    cyc(10);
    chk("t4 held sinal", 32'(sinal), 32'd0);
    chk("t4 held aguardando", 32'(aguardando), 32'd0);
    chk("t4 held valor", 32'(valor), 32'h0BEEF);
    enter = 1'b1;
    cyc(12);
    chk("t4 re-armed aguardando", 32'(aguardando), 32'd1);
    enter = 1'b0;
    wait_sinal(20, "t4 second sinal");
    chk("t4 second valor", 32'(valor), 32'h3C0DE);
    in_r = 1'b0;
    enter = 1'b1;
    cyc(12);

    // 5. Abort in the same cycle the press arrives
    rises = 0;
    entrada = 18'h11111;
    in_r = 1'b1;
    cyc(2);
    enter = 1'b0;
    cyc(6);
    in_r = 1'b0;
    cyc(1);
    chk("t5 sinal", 32'(sinal), 32'd0);
    chk("t5 aguardando", 32'(aguardando), 32'd0);
    chk("t5 valor kept", 32'(valor), 32'h3C0DE);
    cyc(5);
    chk("t5 no rise", 32'(rises), 32'd0);
    enter = 1'b1;
    cyc(10);

    // 6. Reset while value is ready
    entrada = 18'h2FFFF;
    in_r = 1'b1;
    enter = 1'b0;
    wait_sinal(20, "t6 sinal");
    reset = 1'b0;
    cyc(1);
    chk("t6 sinal", 32'(sinal), 32'd0);
    chk("t6 valor", 32'(valor), 32'd0);
    chk("t6 aguardando", 32'(aguardando), 32'd0);
    reset = 1'b1;
    in_r = 1'b0;
    enter = 1'b1;
    cyc(10);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        enter = ~enter;
        hold = $urandom_range(1, 12);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 15) == 0) in_r = ~in_r;
      entrada = 18'($urandom);
      reset = ($urandom_range(0, 299) != 0);
      cyc(1);
    end
    reset = 1'b1;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
